// File: rtl/bin2bcd32_pkg.sv
// Shared widths and FSM state encoding for the 32-bit binary-to-BCD converter.
package bin2bcd32_pkg;

    localparam int BIN_W = 32;
    localparam int NDIG  = 10;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd32_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // 4-bit add with no carry out; inputs above 9 never occur in a valid accumulator.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd32.sv
// Sequential 32-bit binary to 10-digit BCD converter (double-dabble, one bit per cycle).
//
//  state | meaning
//  IDLE  | waiting for en; bcd outputs hold the last result
//  SHIFT | one correct-and-shift iteration per cycle, 32 in total
//  DONE  | result published, fin high for this single cycle
module bin2bcd32 #(
    parameter int BIN_W = bin2bcd32_pkg::BIN_W,
    parameter int NDIG  = bin2bcd32_pkg::NDIG
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [BIN_W-1:0] bin,
    output logic [3:0]       bcd0,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd4,
    output logic [3:0]       bcd5,
    output logic [3:0]       bcd6,
    output logic [3:0]       bcd7,
    output logic [3:0]       bcd8,
    output logic [3:0]       bcd9,
    output logic             busy,
    output logic             fin
);

    import bin2bcd32_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    sr;
    logic [4*NDIG-1:0]   acc;
    logic [4*NDIG-1:0]   corr;
    logic [4*NDIG-1:0]   acc_shifted;
    logic [4*NDIG-1:0]   bcd_q;
    logic                unused_corr_msb;

    // Per-digit add-3 correction applied to the whole accumulator each SHIFT cycle.
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_add3 u_add3 (
            .din  (acc[4*g +: 4]),
            .dout (corr[4*g +: 4])
        );
    end

    // Corrected accumulator shifted left with the binary MSB entering bit 0.
    assign acc_shifted     = {corr[4*NDIG-2:0], sr[BIN_W-1]};
    assign unused_corr_msb = corr[4*NDIG-1];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                fin     = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, shift during SHIFT, publish on the last iteration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            sr    <= '0;
            acc   <= '0;
            bcd_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        sr  <= bin;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    acc <= acc_shifted;
                    sr  <= {sr[BIN_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        bcd_q <= acc_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd0 = bcd_q[3:0];
    assign bcd1 = bcd_q[7:4];
    assign bcd2 = bcd_q[11:8];
    assign bcd3 = bcd_q[15:12];
    assign bcd4 = bcd_q[19:16];
    assign bcd5 = bcd_q[23:20];
    assign bcd6 = bcd_q[27:24];
    assign bcd7 = bcd_q[31:28];
    assign bcd8 = bcd_q[35:32];
    assign bcd9 = bcd_q[39:36];

endmodule

// File: tb/tb_bin2bcd32.sv
// Directed and random checks for bin2bcd32: result digits, latency, busy/fin timing, reset abort.
module tb_bin2bcd32;

    typedef struct packed {
        logic [31:0] bin;
        logic [39:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] bin;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7, bcd8, bcd9;
    logic        busy;
    logic        fin;
    logic [39:0] dig;

    int total = 0;
    int bad   = 0;

    vec_t vecs [12];

    bin2bcd32 dut (
        .CLK  (clk),
        .RST  (rst),
        .en   (en),
        .bin  (bin),
        .bcd0 (bcd0),
        .bcd1 (bcd1),
        .bcd2 (bcd2),
        .bcd3 (bcd3),
        .bcd4 (bcd4),
        .bcd5 (bcd5),
        .bcd6 (bcd6),
        .bcd7 (bcd7),
        .bcd8 (bcd8),
        .bcd9 (bcd9),
        .busy (busy),
        .fin  (fin)
    );

    assign dig = {bcd9, bcd8, bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: repeated divide by ten, independent of the shift/add-3 method.
    function automatic logic [39:0] to_bcd(input logic [31:0] b);
        logic [39:0] r;
        logic [31:0] v;
        r = '0;
        v = b;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(v % 32'd10);
            v = v / 32'd10;
        end
        return r;
    endfunction

    // One conversion. Caller is either already at a negedge in an IDLE cycle (skip_wait=1)
    // or the task moves to the next negedge. If hold=1, en stays high and bin switches to hb
    // during the conversion.
    task automatic run_conv(input string nm, input logic [31:0] b, input logic [39:0] exp,
                            input bit skip_wait, input bit hold, input logic [31:0] hb);
        logic [39:0] prev;
        int lat;
        int bcnt;
        bit held;
        if (!skip_wait) @(negedge clk);
        check({nm, "_idle_pre"}, {62'd0, busy, fin}, 64'd0);
        prev = dig;
        en   = 1'b1;
        bin  = b;
        @(negedge clk);
        if (hold) bin = hb;
        else en = 1'b0;
        lat  = 0;
        bcnt = 0;
        held = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (busy) bcnt++;
            if (!fin && dig !== prev) held = 1'b0;
            if (fin) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        en = 1'b0;
        check({nm, "_latency"}, 64'(lat), 64'd33);
        check({nm, "_busy_cycles"}, 64'(bcnt), 64'd32);
        check({nm, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        check({nm, "_held"}, {63'd0, held}, 64'd1);
        check({nm, "_result"}, {24'd0, dig}, {24'd0, exp});
    endtask

    initial begin
        vecs[0]  = '{bin: 32'd0,          exp: 40'h0000000000};
        vecs[1]  = '{bin: 32'hFFFFFFFF,   exp: 40'h4294967295};
        vecs[2]  = '{bin: 32'h499602D2,   exp: 40'h1234567890};
        vecs[3]  = '{bin: 32'd9,          exp: 40'h0000000009};
        vecs[4]  = '{bin: 32'd10,         exp: 40'h0000000010};
        vecs[5]  = '{bin: 32'd1,          exp: 40'h0000000001};
        vecs[6]  = '{bin: 32'h0001869F,   exp: 40'h0000099999};
        vecs[7]  = '{bin: 32'h3B9AC9FF,   exp: 40'h0999999999};
        vecs[8]  = '{bin: 32'h3B9ACA00,   exp: 40'h1000000000};
        vecs[9]  = '{bin: 32'h80000000,   exp: 40'h2147483648};
        vecs[10] = '{bin: 32'h7FFFFFFF,   exp: 40'h2147483647};
        vecs[11] = '{bin: 32'hEE6B2800,   exp: 40'h4000000000};

        rst = 1'b1;
        en  = 1'b1;
        bin = 32'h12345678;
        repeat (3) @(negedge clk);
        check("reset_digits", {24'd0, dig}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_fin", {63'd0, fin}, 64'd0);

        // Start on the very first edge with reset released.
        rst = 1'b0;
        en  = 1'b0;
        run_conv("vec0_after_reset", vecs[0].bin, vecs[0].exp, 1'b1, 1'b0, 32'd0);

        for (int i = 1; i < 12; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp, 1'b0, 1'b0, 32'd0);
        end

        // en held high with a different bin during the conversion.
        run_conv("hold_en", 32'd100, 40'h0000000100, 1'b0, 1'b1, 32'd7);
        @(negedge clk);
        check("hold_en_no_restart", {62'd0, busy, fin}, 64'd0);

        // Abort in the 10th SHIFT cycle.
        run_conv("pre_abort", 32'd555, 40'h0000000555, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        en  = 1'b1;
        bin = 32'd123456;
        @(negedge clk);
        en = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_fin", {63'd0, fin}, 64'd0);
        check("abort_digits", {24'd0, dig}, 64'd0);
        run_conv("post_abort", 32'd7654321, 40'h0007654321, 1'b1, 1'b0, 32'd0);

        // Back-to-back random conversions against the divide-by-ten model.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r;
            r = $urandom;
            run_conv($sformatf("rand%0d", n), r, to_bcd(r), 1'b0, 1'b0, 32'd0);
        end
        @(negedge clk);
        check("final_idle", {62'd0, busy, fin}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
